// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a byte stream big-endian into 32-bit words,
// appends 0x80, zero fill and the 64-bit message bit length, and emits the
// resulting 16-word blocks one word per handshake.
module sha256_msg_padder #(
  parameter int CNT_W = 29
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        w_valid,
  output logic [31:0] w_data,
  output logic        w_first,
  output logic        w_last,
  input  logic        w_ready
);

  typedef enum logic [1:0] {DATA, PAD_ZERO, LEN_HI, LEN_LO} state_t;

  state_t           state, state_nx;
  logic [1:0]       lane;
  logic [3:0]       widx;
  logic [CNT_W-1:0] bcnt;
  logic [23:0]      asm_sr;
  logic             mark_pend;

  logic             out_free;
  logic             consume;
  logic             accept;
  logic [3:0]       ld_idx;
  logic [63:0]      bit_len;

  logic             load;
  logic [31:0]      ld_data;
  logic             ld_last;
  logic             mark_set;
  logic             mark_clr;
  logic             clr_cnt;

  // Assemble a data word from the bytes collected so far plus the current
  // byte; a short final word gets the 0x80 marker right after its last byte.
  function automatic logic [31:0] pack_word(input logic [1:0] ln,
                                            input logic [23:0] a,
                                            input logic [7:0] b);
    logic [31:0] w;
    case (ln)
      2'd0:    w = {b, 8'h80, 16'h0000};
      2'd1:    w = {a[7:0], b, 8'h80, 8'h00};
      2'd2:    w = {a[15:0], b, 8'h80};
      default: w = {a, b};
    endcase
    return w;
  endfunction

  // The output register accepts a new word when it is empty or being drained;
  // a word loaded while the current one is consumed takes the next index.
  assign out_free = !w_valid || w_ready;
  assign consume  = w_valid && w_ready;
  assign in_ready = (state == DATA) && out_free;
  assign accept   = in_valid && in_ready;
  assign ld_idx   = consume ? widx + 4'd1 : widx;
  assign bit_len  = {{(61-CNT_W){1'b0}}, bcnt, 3'b000};

  // Next-state and output-register load selection.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    ld_data  = 32'h0000_0000;
    ld_last  = 1'b0;
    mark_set = 1'b0;
    mark_clr = 1'b0;
    clr_cnt  = 1'b0;
    case (state)
      DATA: begin
        if (accept && (lane == 2'd3 || in_last)) begin
          load    = 1'b1;
          ld_data = pack_word(lane, asm_sr, in_data);
          if (in_last) begin
            if (lane == 2'd3) begin
              // Marker did not fit: it goes out as a separate word.
              mark_set = 1'b1;
              state_nx = PAD_ZERO;
            end else begin
              state_nx = (ld_idx == 4'd13) ? LEN_HI : PAD_ZERO;
            end
          end
        end
      end
      PAD_ZERO: begin
        if (out_free) begin
          load     = 1'b1;
          ld_data  = mark_pend ? 32'h8000_0000 : 32'h0000_0000;
          mark_clr = 1'b1;
          // Word 13 is the last filler; 14 and 15 carry the length.
          if (ld_idx == 4'd13) state_nx = LEN_HI;
        end
      end
      LEN_HI: begin
        if (out_free) begin
          load     = 1'b1;
          ld_data  = bit_len[63:32];
          state_nx = LEN_LO;
        end
      end
      LEN_LO: begin
        if (out_free) begin
          load     = 1'b1;
          ld_data  = bit_len[31:0];
          ld_last  = 1'b1;
          clr_cnt  = 1'b1;
          state_nx = DATA;
        end
      end
      default: state_nx = DATA;
    endcase
  end

  // State, counters and byte assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DATA;
      lane      <= 2'd0;
      widx      <= 4'd0;
      bcnt      <= '0;
      asm_sr    <= 24'h000000;
      mark_pend <= 1'b0;
    end else begin
      state <= state_nx;
      if (consume) widx <= widx + 4'd1;
      if (accept) begin
        asm_sr <= {asm_sr[15:0], in_data};
        lane   <= in_last ? 2'd0 : lane + 2'd1;
        bcnt   <= bcnt + 1'b1;
      end
      if (clr_cnt) begin
        bcnt <= '0;
        lane <= 2'd0;
      end
      if (mark_set)      mark_pend <= 1'b1;
      else if (mark_clr) mark_pend <= 1'b0;
    end
  end

  // Output word register; holds steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_valid <= 1'b0;
      w_data  <= 32'h0000_0000;
      w_first <= 1'b0;
      w_last  <= 1'b0;
    end else if (load) begin
      w_valid <= 1'b1;
      w_data  <= ld_data;
      w_first <= (ld_idx == 4'd0);
      w_last  <= ld_last;
    end else if (consume) begin
      w_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: a reference padder builds the
// expected word stream for each message, which is popped on every handshake.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        w_valid;
  logic [31:0] w_data;
  logic        w_first;
  logic        w_last;
  logic        w_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [33:0] exp_q[$];
  logic [7:0]  msg_buf [0:255];
  int          rdy_mode = 0;
  int          stall_cnt = 0;
  logic        held_v = 1'b0;
  logic [33:0] held;

  sha256_msg_padder #(.CNT_W(29)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .w_valid(w_valid), .w_data(w_data), .w_first(w_first), .w_last(w_last),
    .w_ready(w_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // w_ready: 0 = always ready, 1 = random, 2 = ready except scripted stalls.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) w_ready = ($urandom_range(0, 2) != 0);
    else if (stall_cnt > 0) begin
      w_ready = 1'b0;
      stall_cnt = stall_cnt - 1;
    end else w_ready = 1'b1;
  end

  // Output monitor: compare consumed words, and check stability under stall.
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst_n && w_valid && w_ready) begin
      if (exp_q.size() == 0) check("extra_word", {32'h0, w_data}, 64'hdead);
      else begin
        e = exp_q.pop_front();
        check("w_data", {32'h0, w_data}, {32'h0, e[31:0]});
        check("w_first", {63'h0, w_first}, {63'h0, e[32]});
        check("w_last", {63'h0, w_last}, {63'h0, e[33]});
      end
      held_v = 1'b0;
    end else if (rst_n && w_valid && !w_ready) begin
      check("in_ready_stall", {63'h0, in_ready}, 64'h0);
      if (held_v) check("hold_stable", {30'h0, w_last, w_first, w_data}, {30'h0, held});
      held = {w_last, w_first, w_data};
      held_v = 1'b1;
    end else held_v = 1'b0;
  end

  // Reference padding of msg_buf[0:len-1] into expected words.
  task automatic push_exp(input int len);
    logic [7:0]  p [0:255];
    logic [63:0] bl;
    int total, nw, k;
    total = ((len + 8) / 64 + 1) * 64;
    bl = 64'(len) * 64'd8;
    for (int i = 0; i < total; i++) begin
      if (i < len) p[i] = msg_buf[i];
      else if (i == len) p[i] = 8'h80;
      else if (i >= total - 8) begin
        k = i - (total - 8);
        p[i] = bl[63 - 8*k -: 8];
      end else p[i] = 8'h00;
    end
    nw = total / 4;
    for (int i = 0; i < nw; i++)
      exp_q.push_back({(i == nw - 1), (i % 16 == 0),
                       p[4*i], p[4*i+1], p[4*i+2], p[4*i+3]});
  endtask

  task automatic send_msg(input int len, input bit gaps);
    int t;
    push_exp(len);
    for (int i = 0; i < len; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = msg_buf[i];
      in_last  = (i == len - 1);
      t = 0;
      forever begin
        @(negedge clk);
        if (in_ready) break;
        t++;
        if (t > 1000) begin
          check("accept_timeout", 64'h0, 64'h1);
          in_valid = 1'b0;
          in_last  = 1'b0;
          return;
        end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check(tag, 64'(exp_q.size()), 64'h0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic fill_abc(input int len);
    for (int i = 0; i < len; i++) msg_buf[i] = 8'h61 + 8'(i % 26);
  endtask

  task automatic fill_rand(input int len);
    for (int i = 0; i < len; i++) msg_buf[i] = 8'($urandom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    repeat (3) @(posedge clk);
    #1;
    check("rst_w_valid", {63'h0, w_valid}, 64'h0);
    check("rst_w_data", {32'h0, w_data}, 64'h0);
    check("rst_w_first", {63'h0, w_first}, 64'h0);
    check("rst_w_last", {63'h0, w_last}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {63'h0, in_ready}, 64'h1);

    // "abc", "abcd", 55 and 56 bytes with continuous ready
    fill_abc(3);  send_msg(3, 0);  drain("drain_abc");
    fill_abc(4);  send_msg(4, 0);  drain("drain_abcd");
    fill_abc(55); send_msg(55, 0); drain("drain_55");
    fill_abc(56); send_msg(56, 0); drain("drain_56");

    // Scripted 5-cycle stall mid-message
    rdy_mode = 2;
    fill_rand(64);
    fork
      send_msg(64, 0);
      begin
        repeat (9) @(posedge clk);
        #2;
        stall_cnt = 5;
      end
    join
    drain("drain_stall");

    // Random lengths, random ready, idle gaps with stray in_last
    rdy_mode = 1;
    foreach (msg_buf[i]) msg_buf[i] = 8'h00;
    for (int m = 0; m < 8; m++) begin
      case (m)
        0: len = 1;
        1: len = 52;
        2: len = 63;
        3: len = 64;
        4: len = 119;
        5: len = 120;
        default: len = $urandom_range(1, 200);
      endcase
      fill_rand(len);
      send_msg(len, 1);
    end
    drain("drain_rand");

    // Reset while padding, then "abc" again
    rdy_mode = 0;
    fill_abc(56);
    send_msg(56, 0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_w_valid", {63'h0, w_valid}, 64'h0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("inreset_w_valid", {63'h0, w_valid}, 64'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    fill_abc(3); send_msg(3, 0); drain("drain_abc_after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
